frame_consumer_arbiter: RTL and testbench
=========================================

Name: frame_consumer_arbiter

Overview:
Shares the single header FIFO and body packet FIFO after the MAC decoder between two consumers: the SoC frame fetcher and the L2 MAC switch. It classifies each frame from the head-of-queue header, grants one consumer exclusive ownership, and routes that consumer's read strobes through. It releases ownership once the header word and the last body byte have both been read. This block replaces the plain OR of the two consumers' read enables.

Parameters:
HEADER_DWIDTH, 128, header FIFO word width
DMAC_LSB, 0, bit position of the 48-bit destination MAC inside the header word
WDOG_CYCLES, 4096, stall limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock (100 MHz)
arst_n  in  1  asynchronous active-low reset
cfg_own_mac  in  48  MAC address owned by the SoC
cfg_bcast_to_soc  in  1  1: broadcast frames go to the SoC; 0: broadcast frames go to the switch
h_fifo_dout  in  HEADER_DWIDTH  header FIFO head word (first-word fall-through)
h_fifo_empty  in  1  header FIFO empty
h_fifo_rden  out  1  header FIFO read
b_fifo_empty  in  1  body FIFO empty
b_fifo_del  in  1  head body byte is the last byte of its frame
b_fifo_rden  out  1  body FIFO read
soc_h_rden, soc_b_rden  in  1 each  SoC read requests
soc_h_empty, soc_b_empty  out  1 each  gated empty flags seen by the SoC
sw_h_rden, sw_b_rden  in  1 each  switch read requests
sw_h_empty, sw_b_empty  out  1 each  gated empty flags seen by the switch
owner  out  2  00 none, 01 SoC, 10 switch, 11 drain
drop_cnt  out  16  saturating count of drained frames (reads 0 when the optional feature is compiled out)

Behaviour:
- Reset: state IDLE, owner=00, all rden=0, all gated empty flags=1, drop_cnt=0, h_done=0.
- IDLE: if !h_fifo_empty, go to CLASSIFY next cycle.
- CLASSIFY (1 cycle): dmac = h_fifo_dout[DMAC_LSB+47:DMAC_LSB].
  - SoC if dmac==cfg_own_mac, or if dmac==48'hFFFF_FFFF_FFFF and cfg_bcast_to_soc=1.
  - Otherwise switch.
  - Decision and config are registered; later config changes do not affect the current frame.
  - Ownership is visible on the following cycle, so header-available to owner grant is 2 cycles.
- OWN_SOC / OWN_SW, gating:
  - Owner's empty flags = FIFO empty flags.
  - Non-owner's empty flags forced to 1.
  - h_fifo_rden = owner_h_rden & !h_fifo_empty & !h_done.
  - b_fifo_rden = owner_b_rden & !b_fifo_empty.
  - Non-owner requests are ignored, never forwarded.
- Header accounting: h_done is set on the first h_fifo_rden pulse. Further header reads are masked until release, so exactly one header word is consumed per frame.
- Release condition: (b_fifo_rden & b_fifo_del) in a cycle with h_done=1, or arriving in the same cycle as the header read.
  - Next state is IDLE, h_done cleared, owner=00.
  - IDLE may re-enter CLASSIFY on the cycle after release, so back-to-back frames are supported.
- Body-before-header: if the last body byte is read while h_done=0, ownership holds until the header is read, then releases.
- Empty FIFOs: rden is never asserted on an empty FIFO, regardless of requests.
- arst_n asserted mid-frame: immediate return to reset values. The partially read frame is not recovered; upstream FIFOs are reset by the same reset.

Optional Feature:
Macro FCA_WATCHDOG_EN.
- With the macro:
  - A 16-bit stall counter increments each cycle in OWN_SOC/OWN_SW with no rden issued.
  - The counter clears on any read.
  - On reaching WDOG_CYCLES, the block enters DRAIN (owner=11); both consumers see empty=1.
  - In DRAIN the block asserts b_fifo_rden whenever !b_fifo_empty, and h_fifo_rden once if !h_done.
  - DRAIN exits to IDLE on the last body byte read with the header consumed; drop_cnt increments, saturating at 16'hFFFF.
- Without the macro: no counter, no DRAIN state, drop_cnt tied to 0, and a stalled owner holds ownership indefinitely.

Decomposition:
- Shared package:
  - State encoding: IDLE, CLASSIFY, OWN_SOC, OWN_SW, DRAIN.
  - owner encoding constants.
  - Broadcast MAC constant 48'hFFFF_FFFF_FFFF.
  - MAC width constant 48.
- Sub-module: fca_classifier, combinational dmac extraction and compare, registered by the parent.

Test Plan:
- Unicast to the SoC:
  - Stimulus: header dmac = cfg_own_mac = 48'h02_00_00_00_00_01, 64-byte body, SoC reads.
  - Required: owner=01 two cycles after !h_fifo_empty; 1 header and 64 body reads forwarded; sw_*_empty=1 throughout; owner=00 the cycle after the del byte.
- Broadcast, config 0 then 1:
  - Stimulus: dmac=FFFF_FFFF_FFFF with cfg_bcast_to_soc=0, then 1.
  - Required: first frame owner=10, second owner=01.
- Back-to-back frames:
  - Stimulus: frame A to the switch, frame B to the SoC, both queued.
  - Required: release of A, IDLE, CLASSIFY, owner=01 within 3 cycles; no byte of B is read by the switch.
- Cross-consumer and repeated requests:
  - Stimulus: non-owner asserts rden during an owned frame; owner issues a second h_rden.
  - Required: no FIFO read from the non-owner; the second header read is masked.
- Body-before-header and empty gating:
  - Stimulus: owner reads all body bytes before the header; requests continue while FIFOs are empty.
  - Required: release only after the header read; rden never asserted while empty.
- Watchdog and reset (FCA_WATCHDOG_EN, WDOG_CYCLES=16):
  - Stimulus: owner stalls 16 cycles.
  - Required: owner=11; the remaining frame is drained; drop_cnt=1; next frame classified normally.
  - Stimulus: arst_n pulsed mid-frame.
  - Required: all outputs return to reset values.

Source files
------------

// File: rtl/frame_consumer_arbiter_pkg.sv
// Shared types for the header/body FIFO consumer arbiter.
// States, owner codes and MAC constants.
package frame_consumer_arbiter_pkg;

  localparam int MAC_W = 48;
  localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_SOC   = 2'b01;
  localparam logic [1:0] OWN_SW    = 2'b10;
  localparam logic [1:0] OWN_DRAIN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_OWN_SOC,
    ST_OWN_SW,
    ST_DRAIN
  } state_t;

  function automatic logic [1:0] owner_of(state_t s);
    logic [1:0] o;
    o = OWN_NONE;
    case (s)
      ST_OWN_SOC: o = OWN_SOC;
      ST_OWN_SW:  o = OWN_SW;
      ST_DRAIN:   o = OWN_DRAIN;
      default:    o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fca_classifier.sv
// Destination MAC extraction and SoC/switch decision.
// Purely combinational; the parent registers the result.
module fca_classifier
  import frame_consumer_arbiter_pkg::*;
#(
  parameter int HEADER_DWIDTH = 128,
  parameter int DMAC_LSB      = 0
) (
  input  logic [HEADER_DWIDTH-1:0] i_hdr,
  input  logic [MAC_W-1:0]         i_own_mac,
  input  logic                     i_bcast_to_soc,
  output logic                     o_to_soc
);

  logic [MAC_W-1:0] w_dmac;
  logic             w_hdr_unused;

  assign w_dmac = i_hdr[DMAC_LSB +: MAC_W];

  assign o_to_soc =
    (w_dmac == i_own_mac) |
    ((w_dmac == BCAST_MAC) & i_bcast_to_soc);

  // Only the DMAC field matters here.
  assign w_hdr_unused = ^i_hdr;

endmodule

// File: rtl/frame_consumer_arbiter.sv
// Grants header/body FIFO ownership to the SoC or the L2 switch.
// Optional stall watchdog with frame drain: FCA_WATCHDOG_EN.
module frame_consumer_arbiter
  import frame_consumer_arbiter_pkg::*;
#(
  parameter int HEADER_DWIDTH = 128,
  parameter int DMAC_LSB      = 0,
  parameter int WDOG_CYCLES   = 4096
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [47:0]              cfg_own_mac,
  input  logic                     cfg_bcast_to_soc,
  input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
  input  logic                     h_fifo_empty,
  output logic                     h_fifo_rden,
  input  logic                     b_fifo_empty,
  input  logic                     b_fifo_del,
  output logic                     b_fifo_rden,
  input  logic                     soc_h_rden,
  input  logic                     soc_b_rden,
  output logic                     soc_h_empty,
  output logic                     soc_b_empty,
  input  logic                     sw_h_rden,
  input  logic                     sw_b_rden,
  output logic                     sw_h_empty,
  output logic                     sw_b_empty,
  output logic [1:0]               owner,
  output logic [15:0]              drop_cnt
);

  localparam logic [15:0] LP_WDOG_LAST = 16'(WDOG_CYCLES - 1);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_h_done;
  logic   r_b_done;
  logic   w_h_done_nxt;
  logic   w_b_done_nxt;
  logic   w_to_soc;
  logic   w_own_h;
  logic   w_own_b;
  logic   w_owned;
  logic   w_h_ok;
  logic   w_b_ok;
  logic   w_rel;
  logic   w_stall_hit;

  fca_classifier #(
    .HEADER_DWIDTH (HEADER_DWIDTH),
    .DMAC_LSB      (DMAC_LSB)
  ) u_cls (
    .i_hdr          (h_fifo_dout),
    .i_own_mac      (cfg_own_mac),
    .i_bcast_to_soc (cfg_bcast_to_soc),
    .o_to_soc       (w_to_soc)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= ST_IDLE;
      r_h_done <= 1'b0;
      r_b_done <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_h_done <= w_h_done_nxt;
      r_b_done <= w_b_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_own_h     = 1'b0;
    w_own_b     = 1'b0;
    w_owned     = 1'b0;
    soc_h_empty = 1'b1;
    soc_b_empty = 1'b1;
    sw_h_empty  = 1'b1;
    sw_b_empty  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!h_fifo_empty) w_state_nxt = ST_CLASSIFY;
      end
      ST_CLASSIFY: begin
        w_state_nxt = w_to_soc ? ST_OWN_SOC : ST_OWN_SW;
      end
      ST_OWN_SOC: begin
        w_owned     = 1'b1;
        soc_h_empty = h_fifo_empty;
        soc_b_empty = b_fifo_empty;
        w_own_h     = soc_h_rden;
        w_own_b     = soc_b_rden;
      end
      ST_OWN_SW: begin
        w_owned    = 1'b1;
        sw_h_empty = h_fifo_empty;
        sw_b_empty = b_fifo_empty;
        w_own_h    = sw_h_rden;
        w_own_b    = sw_b_rden;
      end
`ifdef FCA_WATCHDOG_EN
      ST_DRAIN: begin
        w_owned = 1'b1;
        w_own_h = 1'b1;
        w_own_b = 1'b1;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    // Once a frame's last byte is taken, body reads stay masked.
    h_fifo_rden = w_own_h & ~h_fifo_empty & ~r_h_done;
    b_fifo_rden = w_own_b & ~b_fifo_empty & ~r_b_done;

    w_h_ok = r_h_done | h_fifo_rden;
    w_b_ok = r_b_done | (b_fifo_rden & b_fifo_del);
    w_rel  = w_owned & w_h_ok & w_b_ok;

    w_h_done_nxt = w_owned & w_h_ok & ~w_rel;
    w_b_done_nxt = w_owned & w_b_ok & ~w_rel;

    if (w_rel) begin
      w_state_nxt = ST_IDLE;
    end else if (w_stall_hit) begin
      w_state_nxt = ST_DRAIN;
    end
  end

  assign owner = owner_of(r_state);

`ifdef FCA_WATCHDOG_EN
  logic [15:0] r_wdog;
  logic [15:0] r_drop;
  logic        w_live;
  logic        w_any_rd;

  assign w_live   = (r_state == ST_OWN_SOC) |
                    (r_state == ST_OWN_SW);
  assign w_any_rd = h_fifo_rden | b_fifo_rden;
  assign w_stall_hit = w_live & ~w_any_rd &
                       (r_wdog == LP_WDOG_LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wdog <= 16'h0;
      r_drop <= 16'h0;
    end else begin
      if (!w_live || w_any_rd || w_stall_hit) begin
        r_wdog <= 16'h0;
      end else begin
        r_wdog <= r_wdog + 16'h1;
      end
      if ((r_state == ST_DRAIN) && w_rel &&
          (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'h1;
      end
    end
  end

  assign drop_cnt = r_drop;
`else
  logic [15:0] w_wdog_unused;

  assign w_wdog_unused = LP_WDOG_LAST;
  assign w_stall_hit   = 1'b0;
  assign drop_cnt      = 16'h0;
`endif

endmodule

// File: tb/tb_frame_consumer_arbiter.sv
// Directed bench for frame_consumer_arbiter.
// FIFOs are modelled by queues; vectors plus corner-case sequences.
module tb_frame_consumer_arbiter;

  logic         clk;
  logic         arst_n;
  logic [47:0]  cfg_own_mac;
  logic         cfg_bcast_to_soc;
  logic [127:0] h_fifo_dout;
  logic         h_fifo_empty;
  logic         h_fifo_rden;
  logic         b_fifo_empty;
  logic         b_fifo_del;
  logic         b_fifo_rden;
  logic         soc_h_rden;
  logic         soc_b_rden;
  logic         soc_h_empty;
  logic         soc_b_empty;
  logic         sw_h_rden;
  logic         sw_b_rden;
  logic         sw_h_empty;
  logic         sw_b_empty;
  logic [1:0]   owner;
  logic [15:0]  drop_cnt;

  localparam logic [47:0] OWN = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTH = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;

  frame_consumer_arbiter #(
    .HEADER_DWIDTH (128),
    .DMAC_LSB      (0),
    .WDOG_CYCLES   (16)
  ) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .cfg_own_mac      (cfg_own_mac),
    .cfg_bcast_to_soc (cfg_bcast_to_soc),
    .h_fifo_dout      (h_fifo_dout),
    .h_fifo_empty     (h_fifo_empty),
    .h_fifo_rden      (h_fifo_rden),
    .b_fifo_empty     (b_fifo_empty),
    .b_fifo_del       (b_fifo_del),
    .b_fifo_rden      (b_fifo_rden),
    .soc_h_rden       (soc_h_rden),
    .soc_b_rden       (soc_b_rden),
    .soc_h_empty      (soc_h_empty),
    .soc_b_empty      (soc_b_empty),
    .sw_h_rden        (sw_h_rden),
    .sw_b_rden        (sw_b_rden),
    .sw_h_empty       (sw_h_empty),
    .sw_b_empty       (sw_b_empty),
    .owner            (owner),
    .drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  logic [127:0] hq[$];
  logic [8:0]   bq[$];

  int checks;
  int failures;
  int viol;
  int n_soc_h, n_soc_b;
  int n_sw_h, n_sw_b;
  int n_dr_h, n_dr_b;

  typedef struct {
    logic [47:0] dmac;
    logic [47:0] own;
    logic        bc;
    logic [1:0]  exp;
  } vec_t;

  vec_t tv[6];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic upd();
    h_fifo_empty = (hq.size() == 0);
    b_fifo_empty = (bq.size() == 0);
    h_fifo_dout  = '0;
    b_fifo_del   = 1'b0;
    if (hq.size() != 0) h_fifo_dout = hq[0];
    if (bq.size() != 0) b_fifo_del  = bq[0][8];
  endtask

  task automatic push_frame(logic [47:0] dmac, int nb);
    hq.push_back({16'hC0DE, 64'h1234_5678_9ABC_DEF0, dmac});
    for (int i = 0; i < nb; i++)
      bq.push_back({(i == nb - 1), 8'(i)});
    upd();
  endtask

  task automatic clr_req();
    soc_h_rden = 1'b0;
    soc_b_rden = 1'b0;
    sw_h_rden  = 1'b0;
    sw_b_rden  = 1'b0;
  endtask

  task automatic zero_cnt();
    n_soc_h = 0; n_soc_b = 0;
    n_sw_h  = 0; n_sw_b  = 0;
    n_dr_h  = 0; n_dr_b  = 0;
  endtask

  // One clock: audit outputs mid-cycle, then pop what was read.
  task automatic tick();
    logic hr, br;
    @(negedge clk);
    hr = h_fifo_rden;
    br = b_fifo_rden;
    if (hr && h_fifo_empty) viol++;
    if (br && b_fifo_empty) viol++;
    case (owner)
      2'b01: begin
        if (soc_h_empty !== h_fifo_empty) viol++;
        if (soc_b_empty !== b_fifo_empty) viol++;
        if (!sw_h_empty || !sw_b_empty) viol++;
        if (hr && !soc_h_rden) viol++;
        if (br && !soc_b_rden) viol++;
        n_soc_h += int'(hr);
        n_soc_b += int'(br);
      end
      2'b10: begin
        if (sw_h_empty !== h_fifo_empty) viol++;
        if (sw_b_empty !== b_fifo_empty) viol++;
        if (!soc_h_empty || !soc_b_empty) viol++;
        if (hr && !sw_h_rden) viol++;
        if (br && !sw_b_rden) viol++;
        n_sw_h += int'(hr);
        n_sw_b += int'(br);
      end
      2'b11: begin
        if (!soc_h_empty || !soc_b_empty) viol++;
        if (!sw_h_empty || !sw_b_empty) viol++;
        n_dr_h += int'(hr);
        n_dr_b += int'(br);
      end
      default: begin
        if (!soc_h_empty || !soc_b_empty) viol++;
        if (!sw_h_empty || !sw_b_empty) viol++;
        if (hr || br) viol++;
      end
    endcase
    @(posedge clk);
    #1;
    if (hr && hq.size() != 0) void'(hq.pop_front());
    if (br && bq.size() != 0) void'(bq.pop_front());
    upd();
  endtask

  task automatic run_until_idle(output int n);
    n = 0;
    while (owner != 2'b00 && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n, m;

  initial begin
    tv[0] = '{OWN, OWN, 1'b0, 2'b01};
    tv[1] = '{BC,  OWN, 1'b0, 2'b10};
    tv[2] = '{BC,  OWN, 1'b1, 2'b01};
    tv[3] = '{OTH, OWN, 1'b1, 2'b10};
    tv[4] = '{48'h02_00_00_00_00_03, OWN, 1'b1, 2'b10};
    tv[5] = '{OTH, OTH, 1'b0, 2'b01};

    checks = 0; failures = 0; viol = 0;
    zero_cnt();
    clk = 1'b0;
    arst_n = 1'b0;
    cfg_own_mac = OWN;
    cfg_bcast_to_soc = 1'b0;
    clr_req();
    soc_h_rden = 1'b1;
    upd();
    #12;
    chk("rst_owner", 64'(owner), 0);
    chk("rst_rden", 64'({h_fifo_rden, b_fifo_rden}), 0);
    chk("rst_empty", 64'({soc_h_empty, soc_b_empty,
                          sw_h_empty, sw_b_empty}), 4'hF);
    chk("rst_drop", 64'(drop_cnt), 0);
    clr_req();
    @(posedge clk); #1;
    arst_n = 1'b1;

    // Unicast to SoC, 64-byte body
    push_frame(OWN, 64);
    zero_cnt();
    tick();
    chk("uc_classify_owner", 64'(owner), 0);
    tick();
    chk("uc_grant_owner", 64'(owner), 1);
    soc_h_rden = 1'b1;
    soc_b_rden = 1'b1;
    run_until_idle(n);
    chk("uc_release_cycles", 64'(n), 64);
    chk("uc_soc_h_reads", 64'(n_soc_h), 1);
    chk("uc_soc_b_reads", 64'(n_soc_b), 64);
    chk("uc_sw_reads", 64'(n_sw_h + n_sw_b), 0);
    clr_req();

    // Classification vectors
    for (int i = 0; i < 6; i++) begin
      cfg_own_mac = tv[i].own;
      cfg_bcast_to_soc = tv[i].bc;
      push_frame(tv[i].dmac, 1);
      tick();
      chk($sformatf("tv%0d_classify", i), 64'(owner), 0);
      tick();
      chk($sformatf("tv%0d_owner", i), 64'(owner),
          64'(tv[i].exp));
      if (tv[i].exp == 2'b01)
        chk($sformatf("tv%0d_hempty", i),
            64'(soc_h_empty), 0);
      else
        chk($sformatf("tv%0d_hempty", i),
            64'(sw_h_empty), 0);
      cfg_own_mac = ~tv[i].own;
      cfg_bcast_to_soc = ~tv[i].bc;
      tick();
      chk($sformatf("tv%0d_cfg_hold", i), 64'(owner),
          64'(tv[i].exp));
      if (tv[i].exp == 2'b01) begin
        soc_h_rden = 1'b1; soc_b_rden = 1'b1;
      end else begin
        sw_h_rden = 1'b1; sw_b_rden = 1'b1;
      end
      tick();
      chk($sformatf("tv%0d_release", i), 64'(owner), 0);
      clr_req();
    end
    cfg_own_mac = OWN;
    cfg_bcast_to_soc = 1'b0;

    // Back-to-back: A to switch, B to SoC
    zero_cnt();
    push_frame(OTH, 3);
    push_frame(OWN, 2);
    sw_h_rden = 1'b1;
    sw_b_rden = 1'b1;
    tick(); tick();
    chk("b2b_a_owner", 64'(owner), 2);
    run_until_idle(n);
    chk("b2b_a_cycles", 64'(n), 3);
    m = 0;
    while (owner != 2'b01 && m < 10) begin
      tick();
      m++;
    end
    chk("b2b_gap_le3", 64'(m <= 3), 1);
    soc_h_rden = 1'b1;
    soc_b_rden = 1'b1;
    run_until_idle(n);
    chk("b2b_sw_h", 64'(n_sw_h), 1);
    chk("b2b_sw_b", 64'(n_sw_b), 3);
    chk("b2b_soc_b", 64'(n_soc_b), 2);
    clr_req();

    // Non-owner requests and a repeated header read
    zero_cnt();
    push_frame(OWN, 4);
    push_frame(OTH, 2);
    tick(); tick();
    sw_h_rden = 1'b1;
    sw_b_rden = 1'b1;
    repeat (3) tick();
    chk("xc_sw_reads", 64'(n_sw_h + n_sw_b), 0);
    soc_h_rden = 1'b1;
    repeat (3) tick();
    chk("xc_hdr_once", 64'(n_soc_h), 1);
    chk("xc_hold_owner", 64'(owner), 1);
    soc_b_rden = 1'b1;
    run_until_idle(n);
    chk("xc_soc_b", 64'(n_soc_b), 4);
    soc_h_rden = 1'b0;
    soc_b_rden = 1'b0;
    n = 0;
    while ((hq.size() != 0 || owner != 2'b00) && n < 50) begin
      tick();
      n++;
    end
    chk("xc_sw_h", 64'(n_sw_h), 1);
    chk("xc_sw_b", 64'(n_sw_b), 2);
    clr_req();

    // Body before header, then requests into empty FIFOs
    zero_cnt();
    push_frame(OWN, 3);
    tick(); tick();
    soc_b_rden = 1'b1;
    repeat (6) tick();
    chk("bbh_b_reads", 64'(n_soc_b), 3);
    chk("bbh_hold", 64'(owner), 1);
    soc_h_rden = 1'b1;
    tick();
    chk("bbh_h_reads", 64'(n_soc_h), 1);
    chk("bbh_release", 64'(owner), 0);
    sw_h_rden = 1'b1;
    sw_b_rden = 1'b1;
    repeat (3) tick();
    chk("bbh_idle_empty", 64'(owner), 0);
    clr_req();

    // Reset mid-frame
    push_frame(OWN, 8);
    tick(); tick();
    soc_b_rden = 1'b1;
    tick(); tick();
    soc_h_rden = 1'b1;
    arst_n = 1'b0;
    #1;
    chk("mr_owner", 64'(owner), 0);
    chk("mr_rden", 64'({h_fifo_rden, b_fifo_rden}), 0);
    chk("mr_empty", 64'({soc_h_empty, soc_b_empty,
                         sw_h_empty, sw_b_empty}), 4'hF);
    chk("mr_drop", 64'(drop_cnt), 0);
    hq.delete();
    bq.delete();
    upd();
    @(posedge clk); #1;
    arst_n = 1'b1;
    tick();
    chk("mr_after_owner", 64'(owner), 0);
    clr_req();

`ifdef FCA_WATCHDOG_EN
    zero_cnt();
    push_frame(OWN, 5);
    push_frame(OWN, 1);
    tick(); tick();
    repeat (15) tick();
    chk("wd_before", 64'(owner), 1);
    tick();
    chk("wd_drain", 64'(owner), 3);
    run_until_idle(n);
    chk("wd_drain_h", 64'(n_dr_h), 1);
    chk("wd_drain_b", 64'(n_dr_b), 5);
    chk("wd_drop", 64'(drop_cnt), 1);
    tick(); tick();
    chk("wd_next_owner", 64'(owner), 1);
    soc_h_rden = 1'b1;
    soc_b_rden = 1'b1;
    run_until_idle(n);
    chk("wd_next_cycles", 64'(n), 1);
    chk("wd_drop_keep", 64'(drop_cnt), 1);
    clr_req();
`endif

    chk("audit_violations", 64'(viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
